lfsr_seq_ctrl: RTL and testbench
================================

LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

Interface
REQ-001 SHALL have parameter C_AXIL_ADDR_WIDTH, default 4, AXI-Lite address width.
REQ-002 SHALL have parameter C_AXIL_DATA_WIDTH, default 32, AXI-Lite data width.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, beat-count width.
REQ-004 SHALL have ports, one per line (name, direction, width, meaning):
- aclk  in  1  single clock; all logic on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- cmd_valid/cmd_ready  in/out  1/1  run-command handshake.
- cmd_seed, cmd_taps  in  8 each  LFSR seed and tap mask.
- cmd_count  in  CNT_WIDTH  stream beats to allow before stopping.
- abort  in  1  stop the current run early.
- busy  out  1  high from command accept until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky write error; cleared on next command accept.
- m_axi_awaddr  out  C_AXIL_ADDR_WIDTH  write address.
- m_axi_awvalid/m_axi_awready  out/in  1/1  address handshake.
- m_axi_wdata  out  C_AXIL_DATA_WIDTH  write data.
- m_axi_wvalid/m_axi_wready  out/in  1/1  data handshake.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid/m_axi_bready  in/out  1/1  response handshake.
- mon_tvalid, mon_tready  in  1 each  passive tap of the LFSR AXI-Stream handshake.

Function
REQ-005 cmd_ready SHALL be high only in IDLE; a command is accepted on cmd_valid&&cmd_ready, and seed/taps/count SHALL be latched that cycle.
REQ-006 FSM states: IDLE, WR_SEED, WR_TAPS, WR_STOP0, WR_START1, RUN, WR_STOP1, WR_START0, DONE.
REQ-007 Writes in order SHALL be: 0x8=seed, 0xC=taps, 0x4=0, 0x0=1, then RUN, then 0x4=1, 0x0=0. Upper wdata bits SHALL be zero.
REQ-008 Each write SHALL assert awvalid and wvalid in the same cycle; each valid SHALL drop independently on its own ready; addr/data SHALL be stable while valid.
REQ-009 bready SHALL be high once both AW and W are accepted; the state SHALL advance on bvalid&&bready.
REQ-010 Only one write SHALL be outstanding; the next write's valids SHALL rise no earlier than the cycle after the B handshake.
REQ-011 RUN SHALL count cycles with mon_tvalid&&mon_tready (CNT_WIDTH counter, zeroed on entry) and exit to WR_STOP1 when count==cmd_count.
REQ-012 cmd_count==0: WR_START1 SHALL go directly to WR_STOP1, skipping RUN.
REQ-013 A beat and count match in the same cycle SHALL both be honoured: the beat is counted and the exit occurs.
REQ-014 abort high in RUN SHALL exit to WR_STOP1 the next cycle; abort outside RUN SHALL be ignored.
REQ-015 bresp!=2'b00 on any write SHALL set err; if the failing write is before RUN, the FSM SHALL skip to WR_STOP1 and still complete both cleanup writes.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 busy SHALL equal (state!=IDLE).

Reset
REQ-018 On aresetn low, the FSM SHALL go to IDLE immediately (asynchronously), even mid-transaction.
REQ-019 During reset all valids, bready, done, err, busy and the counter SHALL be 0 and cmd_ready SHALL be 1; awaddr and wdata SHALL be 0.
REQ-020 No bus transaction SHALL be resumed after reset release.

Structure
REQ-021 Package lfsr_seq_pkg SHALL hold the state enum, the register addresses (START 0x0, STOP 0x4, SEED 0x8, TAPS 0xC) and the BRESP constants OKAY and DECERR.
REQ-022 One sub-module, axil_wr_master, SHALL perform a single AW/W/B transaction (go, addr, data -> busy, done, resp); the FSM SHALL sequence it.

Verification
REQ-023 seed=0x5A, taps=0xB8, count=3, slave always ready -> writes (8,5A),(C,B8),(4,0),(0,1); 3 beats; (4,1),(0,0); done once; err=0.
REQ-024 count=0 -> (0,1) followed directly by (4,1) and (0,0); no beats required; done pulses.
REQ-025 awready delayed 3 cycles and wready 1 cycle -> valids drop independently; bready rises only after both handshakes; write order unchanged.
REQ-026 bresp=2'b11 on the taps write -> err=1; next writes are (4,1),(0,0); done; err clears on next accept.
REQ-027 count=100 and abort pulsed after beat 10 -> (4,1) issued next; done pulses; counter stops at 10.
REQ-028 aresetn low during the WR_STOP0 data phase -> outputs at reset values immediately; a new command after release starts from the seed write.

Source files
------------

// File: rtl/lfsr_seq_pkg.sv
// Shared definitions for the LFSR sequencing controller.
// Holds the controller state encoding, the register map of the LFSR
// peripheral that is programmed over AXI-Lite, and the BRESP codes.
package lfsr_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_SEED,
    ST_WR_TAPS,
    ST_WR_STOP0,
    ST_WR_START1,
    ST_RUN,
    ST_WR_STOP1,
    ST_WR_START0,
    ST_DONE
  } state_t;

  localparam logic [3:0] REG_START = 4'h0;
  localparam logic [3:0] REG_STOP  = 4'h4;
  localparam logic [3:0] REG_SEED  = 4'h8;
  localparam logic [3:0] REG_TAPS  = 4'hC;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

endpackage

// File: rtl/lfsr_seq_ctrl_axil_wr_master.sv
// Single-transaction AXI-Lite write master.
// A go pulse while idle latches addr/data and raises AWVALID and WVALID
// together; each valid drops on its own ready. BREADY is offered only
// after both address and data were accepted, and done/resp reflect the
// B handshake in the cycle it happens.
// Ports: clk, rst_n (async, active low); go, addr, data (request);
// awaddr/awvalid/awready, wdata/wvalid/wready, bresp/bvalid/bready (bus);
// busy (transaction outstanding), done (B handshake this cycle), resp.
module axil_wr_master #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            resp
);

  assign bready = busy && !awvalid && !wvalid;
  assign done   = bvalid && bready;
  assign resp   = bresp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awaddr  <= '0;
      wdata   <= '0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      busy    <= 1'b0;
    end else if (go && !busy) begin
      awaddr  <= addr;
      wdata   <= data;
      awvalid <= 1'b1;
      wvalid  <= 1'b1;
      busy    <= 1'b1;
    end else begin
      if (awvalid && awready) awvalid <= 1'b0;
      if (wvalid && wready)   wvalid  <= 1'b0;
      if (done)               busy    <= 1'b0;
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// LFSR run sequencer.
// On an accepted command it programs seed and taps, clears STOP, sets
// START, then counts LFSR stream beats seen on the passive monitor tap
// until the requested count is reached or abort is raised, and finally
// sets STOP and clears START. Any non-OKAY write response sets the sticky
// err flag; a failure before the run jumps straight to the cleanup writes.
// Ports: aclk, aresetn (async, active low); cmd_valid/cmd_ready with
// cmd_seed, cmd_taps, cmd_count; abort; busy, done, err status;
// m_axi_* AXI-Lite write channels; mon_tvalid/mon_tready stream tap.
module lfsr_seq_ctrl
  import lfsr_seq_pkg::*;
#(
  parameter int unsigned C_AXIL_ADDR_WIDTH = 4,
  parameter int unsigned C_AXIL_DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH         = 16
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [7:0]                   cmd_seed,
  input  logic [7:0]                   cmd_taps,
  input  logic [CNT_WIDTH-1:0]         cmd_count,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [C_AXIL_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                         m_axi_awvalid,
  input  logic                         m_axi_awready,
  output logic [C_AXIL_DATA_WIDTH-1:0] m_axi_wdata,
  output logic                         m_axi_wvalid,
  input  logic                         m_axi_wready,
  input  logic [1:0]                   m_axi_bresp,
  input  logic                         m_axi_bvalid,
  output logic                         m_axi_bready,
  input  logic                         mon_tvalid,
  input  logic                         mon_tready
);

  state_t                         state, state_nxt;
  logic [7:0]                     seed_q, taps_q;
  logic [CNT_WIDTH-1:0]           count_q, beats;
  logic                           err_q;
  logic                           wr_go, wr_busy, wr_done;
  logic [1:0]                     wr_resp;
  logic [C_AXIL_ADDR_WIDTH-1:0]   wr_addr;
  logic [C_AXIL_DATA_WIDTH-1:0]   wr_data;
  logic                           beat, wr_fail, run_exit;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign err       = err_q;
  assign beat      = mon_tvalid && mon_tready;
  assign wr_fail   = wr_done && (wr_resp != BRESP_OKAY);
  // A beat that lands on the final count still exits this cycle.
  assign run_exit  = abort || (beats == count_q) ||
                     (beat && (beats + CNT_WIDTH'(1)) == count_q);

  always_comb begin
    state_nxt = state;
    wr_go     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    unique case (state)
      ST_IDLE: if (cmd_valid) state_nxt = ST_WR_SEED;
      ST_WR_SEED: begin
        wr_go         = !wr_busy;
        wr_addr       = C_AXIL_ADDR_WIDTH'(REG_SEED);
        wr_data[7:0]  = seed_q;
        if (wr_done) state_nxt = wr_fail ? ST_WR_STOP1 : ST_WR_TAPS;
      end
      ST_WR_TAPS: begin
        wr_go         = !wr_busy;
        wr_addr       = C_AXIL_ADDR_WIDTH'(REG_TAPS);
        wr_data[7:0]  = taps_q;
        if (wr_done) state_nxt = wr_fail ? ST_WR_STOP1 : ST_WR_STOP0;
      end
      ST_WR_STOP0: begin
        wr_go   = !wr_busy;
        wr_addr = C_AXIL_ADDR_WIDTH'(REG_STOP);
        if (wr_done) state_nxt = wr_fail ? ST_WR_STOP1 : ST_WR_START1;
      end
      ST_WR_START1: begin
        wr_go      = !wr_busy;
        wr_addr    = C_AXIL_ADDR_WIDTH'(REG_START);
        wr_data[0] = 1'b1;
        if (wr_done)
          state_nxt = (wr_fail || count_q == '0) ? ST_WR_STOP1 : ST_RUN;
      end
      ST_RUN: if (run_exit) state_nxt = ST_WR_STOP1;
      ST_WR_STOP1: begin
        wr_go      = !wr_busy;
        wr_addr    = C_AXIL_ADDR_WIDTH'(REG_STOP);
        wr_data[0] = 1'b1;
        if (wr_done) state_nxt = ST_WR_START0;
      end
      ST_WR_START0: begin
        wr_go   = !wr_busy;
        wr_addr = C_AXIL_ADDR_WIDTH'(REG_START);
        if (wr_done) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= ST_IDLE;
      seed_q  <= '0;
      taps_q  <= '0;
      count_q <= '0;
      beats   <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && cmd_valid) begin
        seed_q  <= cmd_seed;
        taps_q  <= cmd_taps;
        count_q <= cmd_count;
        err_q   <= 1'b0;
      end
      if (wr_fail) err_q <= 1'b1;
      if (state == ST_WR_START1)     beats <= '0;
      else if (state == ST_RUN && beat) beats <= beats + CNT_WIDTH'(1);
    end
  end

  axil_wr_master #(
    .ADDR_WIDTH (C_AXIL_ADDR_WIDTH),
    .DATA_WIDTH (C_AXIL_DATA_WIDTH)
  ) u_wr (
    .clk     (aclk),
    .rst_n   (aresetn),
    .go      (wr_go),
    .addr    (wr_addr),
    .data    (wr_data),
    .awaddr  (m_axi_awaddr),
    .awvalid (m_axi_awvalid),
    .awready (m_axi_awready),
    .wdata   (m_axi_wdata),
    .wvalid  (m_axi_wvalid),
    .wready  (m_axi_wready),
    .bresp   (m_axi_bresp),
    .bvalid  (m_axi_bvalid),
    .bready  (m_axi_bready),
    .busy    (wr_busy),
    .done    (wr_done),
    .resp    (wr_resp)
  );

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl: a responder on the AXI-Lite side checks every
// completed write against a queue of expected writes filled when a
// command is issued; stream beats and abort are driven to exercise run
// termination, and status outputs are checked around each command.
module tb_lfsr_seq_ctrl;
  import lfsr_seq_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [7:0]  cmd_seed = '0, cmd_taps = '0;
  logic [15:0] cmd_count = '0;
  logic        abort = 1'b0, busy, done, err;
  logic [3:0]  m_axi_awaddr;
  logic        m_axi_awvalid, m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic        m_axi_wvalid, m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0, m_axi_bready;
  logic        mon_tvalid = 1'b0, mon_tready = 1'b0;

  always #5 aclk = ~aclk;

  lfsr_seq_ctrl #(
    .C_AXIL_ADDR_WIDTH (4),
    .C_AXIL_DATA_WIDTH (32),
    .CNT_WIDTH         (16)
  ) dut (
    .aclk (aclk), .aresetn (aresetn),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
    .cmd_seed (cmd_seed), .cmd_taps (cmd_taps), .cmd_count (cmd_count),
    .abort (abort), .busy (busy), .done (done), .err (err),
    .m_axi_awaddr (m_axi_awaddr), .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata (m_axi_wdata), .m_axi_wvalid (m_axi_wvalid),
    .m_axi_wready (m_axi_wready),
    .m_axi_bresp (m_axi_bresp), .m_axi_bvalid (m_axi_bvalid),
    .m_axi_bready (m_axi_bready),
    .mon_tvalid (mon_tvalid), .mon_tready (mon_tready)
  );

  typedef struct packed { logic [3:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];
  int  n_cmp = 0, n_bad = 0;

  // Responder knobs and state.
  int          aw_delay = 0, w_delay = 0, fail_idx = -1;
  int          aw_wait = 0, w_wait = 0, wr_idx = 0, done_pulses = 0;
  bit          aw_hs = 0, w_hs = 0, b_fire = 0, start1_seen = 0;
  logic [3:0]  cap_addr = '0, hold_addr = '0;
  logic [31:0] cap_data = '0, hold_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic wr_t mk(input logic [3:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    return w;
  endfunction

  // Programming writes in order; index 4/5 are the two cleanup writes.
  function automatic wr_t prog_write(input int i, input logic [7:0] s, input logic [7:0] t);
    case (i)
      0:       return mk(REG_SEED, {24'h0, s});
      1:       return mk(REG_TAPS, {24'h0, t});
      2:       return mk(REG_STOP, 32'd0);
      default: return mk(REG_START, 32'd1);
    endcase
  endfunction

  initial forever begin
    @(negedge aclk);
    if (aresetn && done) done_pulses++;
  end

  // AXI-Lite responder and scoreboard monitor.
  initial forever begin
    @(negedge aclk);
    if (!aresetn) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
      aw_hs = 0; w_hs = 0; b_fire = 0; aw_wait = 0; w_wait = 0;
    end else begin
      if (b_fire) begin
        m_axi_bvalid = 0; b_fire = 0;
        aw_hs = 0; w_hs = 0; aw_wait = 0; w_wait = 0;
        check("gap_after_b", {m_axi_awvalid, m_axi_wvalid}, 0);
        if (cap_addr == REG_START && cap_data == 32'd1) start1_seen = 1;
      end
      if (aw_hs) check("aw_drop", m_axi_awvalid, 0);
      if (w_hs)  check("w_drop", m_axi_wvalid, 0);
      if ((m_axi_awvalid || m_axi_wvalid) && !aw_hs && !w_hs && aw_wait == 0 && w_wait == 0)
        check("valids_together", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
      if (m_axi_awvalid && !aw_hs && aw_wait > 0) check("awaddr_stable", m_axi_awaddr, hold_addr);
      if (m_axi_wvalid && !w_hs && w_wait > 0)    check("wdata_stable", m_axi_wdata, hold_data);
      if (m_axi_bready || (aw_hs && w_hs)) check("bready", m_axi_bready, aw_hs && w_hs);
      if (aw_hs && w_hs && !m_axi_bvalid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write: got addr %0h data %0h, none expected", cap_addr, cap_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", cap_addr, e.addr);
          check("wr_data", cap_data, e.data);
        end
        m_axi_bresp  = (wr_idx == fail_idx) ? BRESP_DECERR : BRESP_OKAY;
        m_axi_bvalid = 1;
        wr_idx++;
      end
      if (m_axi_awvalid && !aw_hs) begin
        if (aw_wait == 0) hold_addr = m_axi_awaddr;
        m_axi_awready = (aw_wait >= aw_delay);
        aw_wait++;
        if (m_axi_awready) begin aw_hs = 1; cap_addr = m_axi_awaddr; end
      end else m_axi_awready = 0;
      if (m_axi_wvalid && !w_hs) begin
        if (w_wait == 0) hold_data = m_axi_wdata;
        m_axi_wready = (w_wait >= w_delay);
        w_wait++;
        if (m_axi_wready) begin w_hs = 1; cap_data = m_axi_wdata; end
      end else m_axi_wready = 0;
      b_fire = m_axi_bvalid && m_axi_bready;
    end
  end

  task automatic accept_cmd(input logic [7:0] seed, input logic [7:0] taps, input int cnt);
    @(negedge aclk); #1;
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_seed = seed; cmd_taps = taps; cmd_count = 16'(cnt); cmd_valid = 1;
    @(negedge aclk); #1;
    cmd_valid = 0;
    check("busy_after_accept", busy, 1);
    check("err_cleared", err, 0);
  endtask

  // abort_at < 0: run to count; otherwise abort after that many beats.
  task automatic run_cmd(input logic [7:0] seed, input logic [7:0] taps, input int cnt,
                         input int awd, input int wd, input int fidx, input int abort_at);
    int  n_pre, d0, nb;
    bit  runs, err_exp, seen;
    n_pre   = (fidx >= 0 && fidx < 4) ? fidx + 1 : 4;
    err_exp = (fidx >= 0 && fidx <= 5);
    runs    = (fidx < 0 || fidx > 3) && cnt > 0;
    for (int i = 0; i < n_pre; i++) exp_q.push_back(prog_write(i, seed, taps));
    exp_q.push_back(mk(REG_STOP, 32'd1));
    exp_q.push_back(mk(REG_START, 32'd0));
    aw_delay = awd; w_delay = wd; fail_idx = fidx; wr_idx = 0; start1_seen = 0;
    d0 = done_pulses;
    accept_cmd(seed, taps, cnt);
    if (runs) begin
      // Abort pulses before the run must have no effect.
      for (int t = 0; t < 300; t++) begin
        @(negedge aclk); #1;
        if (start1_seen) break;
        abort = ($urandom % 5 == 0);
      end
      abort = 0;
      check("start1_seen", start1_seen, 1);
      if (start1_seen) begin
        nb = (abort_at >= 0) ? abort_at : cnt;
        for (int i = 0; i < nb; i++) begin
          int gaps;
          gaps = $urandom % 3;
          for (int g = 0; g < gaps; g++) begin
            int r;
            r = $urandom % 3;
            mon_tvalid = (r == 0); mon_tready = (r == 1);
            @(negedge aclk); #1;
            check("early_exit", m_axi_awvalid, 0);
          end
          mon_tvalid = 1; mon_tready = 1;
          @(negedge aclk); #1;
          mon_tvalid = 0; mon_tready = 0;
          check("no_exit_yet", m_axi_awvalid, 0);
        end
        if (abort_at >= 0) begin
          abort = 1;
          @(negedge aclk); #1;
          abort = 0;
          check("abort_exit_lat0", m_axi_awvalid, 0);
        end
        @(negedge aclk); #1;
        check("exit_write_issued", m_axi_awvalid, 1);
        check("exit_write_addr", m_axi_awaddr, REG_STOP);
      end
    end
    seen = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge aclk); #1;
      if (done) begin seen = 1; break; end
    end
    check("done_seen", seen, 1);
    check("err_final", err, err_exp);
    @(negedge aclk); #1;
    check("done_one_cycle", done, 0);
    check("idle_after_done", {busy, cmd_ready}, 2'b01);
    check("done_pulses", done_pulses - d0, 1);
    check("writes_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic reset_test();
    bit seen;
    exp_q.push_back(prog_write(0, 8'hA5, 8'h3C));
    exp_q.push_back(prog_write(1, 8'hA5, 8'h3C));
    aw_delay = 6; w_delay = 6; fail_idx = -1; wr_idx = 0;
    accept_cmd(8'hA5, 8'h3C, 5);
    seen = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge aclk); #1;
      if (m_axi_awvalid && m_axi_awaddr == REG_STOP && m_axi_wdata == 32'd0) begin
        seen = 1; break;
      end
    end
    check("stop0_pending", seen, 1);
    aresetn = 0;
    #1;
    check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 0);
    check("rst_status", {busy, done, err, cmd_ready}, 4'b0001);
    check("rst_awaddr", m_axi_awaddr, 0);
    check("rst_wdata", m_axi_wdata, 0);
    check("writes_before_reset", exp_q.size(), 0);
    exp_q.delete();
    @(negedge aclk); #1;
    aresetn = 1;
    for (int t = 0; t < 4; t++) begin
      @(negedge aclk); #1;
      check("no_resume", {m_axi_awvalid, m_axi_wvalid, busy}, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 0);
    check("reset_status", {busy, done, err, cmd_ready}, 4'b0001);
    check("reset_bus", {m_axi_awaddr, m_axi_wdata}, 0);
    @(negedge aclk); #1;
    aresetn = 1;
    run_cmd(8'h5A, 8'hB8, 3,   0, 0, -1, -1);
    run_cmd(8'h33, 8'h71, 0,   0, 0, -1, -1);
    run_cmd(8'hC3, 8'h1D, 2,   3, 1, -1, -1);
    run_cmd(8'h12, 8'hB8, 4,   0, 0,  1, -1);
    run_cmd(8'h9E, 8'h8E, 100, 1, 0, -1, 10);
    reset_test();
    run_cmd(8'h6B, 8'hE1, 2,   0, 2, -1, -1);
    for (int k = 0; k < 12; k++) begin
      int cnt, fidx, ab;
      cnt  = ($urandom % 5 == 0) ? 0 : 1 + $urandom % 6;
      fidx = ($urandom % 3 == 0) ? int'($urandom % 6) : -1;
      ab   = (cnt > 0 && $urandom % 3 == 0) ? int'($urandom % cnt) : -1;
      run_cmd(8'($urandom), 8'($urandom), cnt, $urandom % 4, $urandom % 4, fidx, ab);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
